// File: rtl/cordic_8b_gain_comp.sv
// Gain-compensation stage for the 8-bit CORDIC datapath.
// Captures one (x, y, z) result per input handshake. x and y are multiplied
// by K/256 with an 8-step shift-add loop, one step per cycle. z passes
// through unscaled. The scaled triple is held on a valid/ready output port.
module cordic_8b_gain_comp #(
  parameter logic [7:0] K = 8'd155
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] x_in,
  input  logic [7:0] y_in,
  input  logic [7:0] z_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] x_out,
  output logic [7:0] y_out,
  output logic [7:0] z_out,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic        [7:0]  x_q, x_d;
  logic        [7:0]  y_q, y_d;
  logic        [7:0]  z_q, z_d;
  logic signed [15:0] acc_x_q, acc_x_d;
  logic signed [15:0] acc_y_q, acc_y_d;
  logic        [2:0]  cnt_q, cnt_d;
  logic        [7:0]  x_out_q, x_out_d;
  logic        [7:0]  y_out_q, y_out_d;
  logic        [7:0]  z_out_q, z_out_d;

  // Sign-extended operands, shifted by the current step index.
  logic signed [15:0] x_ext, y_ext;
  assign x_ext = {{8{x_q[7]}}, x_q};
  assign y_ext = {{8{y_q[7]}}, y_q};

  // Next-state, datapath and handshake decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned, which would infer a latch.
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    acc_x_d = acc_x_q;
    acc_y_d = acc_y_q;
    cnt_d   = cnt_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          y_d     = y_in;
          z_d     = z_in;
          acc_x_d = '0;
          acc_y_d = '0;
          cnt_d   = '0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // |x| <= 128 and K <= 255 keep the product inside 16 signed bits.
        if (K[cnt_q]) begin
          acc_x_d = acc_x_q + (x_ext <<< cnt_q);
          acc_y_d = acc_y_q + (y_ext <<< cnt_q);
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          // Outputs only change on entry to DONE; dropping the low byte is an arithmetic floor.
          x_out_d = acc_x_d[15:8];
          y_out_d = acc_y_d[15:8];
          z_out_d = z_q;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      acc_x_q <= '0;
      acc_y_q <= '0;
      cnt_q   <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      acc_x_q <= acc_x_d;
      acc_y_q <= acc_y_d;
      cnt_q   <= cnt_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
    end
  end

  // Handshake flags depend only on state (and rst), never on in_valid/out_ready.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_MUL);
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;
  assign z_out     = z_out_q;

endmodule
